// File: rtl/keydecode_pkg.sv
// keydecode_pkg
// Shared constants and types for the keypad decoder slice.
//   NUM_KEYS    : number of real keys on the pad (codes 0..NUM_KEYS-1)
//   CODE_W      : width of a key code
//   TIMER_W     : width of the auto-repeat timer
//   key_state_t : decoder FSM state
//   code_valid  : true when a code names a real key
package keydecode_pkg;

    localparam int NUM_KEYS = 20;
    localparam int CODE_W   = 5;
    localparam int TIMER_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        BLOCKED
    } key_state_t;

    function automatic logic code_valid(input logic [CODE_W-1:0] c);
        return c <= CODE_W'(NUM_KEYS - 1);
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// repeat_timer
// 16-bit up-counter used to pace auto-repeat events.
//   clock    : in  system clock
//   reset    : in  synchronous active-high reset, clears the count
//   restart  : in  zero the count at the next edge
//   terminal : in  number of cycles from restart to done; 0 means never done
//   done     : out high for the single cycle in which the interval expires
module repeat_timer
    import keydecode_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               restart,
    input  logic [TIMER_W-1:0] terminal,
    output logic               done
);

    logic [TIMER_W-1:0] count;

    // Saturate at all-ones so an abandoned count can never wrap back into
    // a value that would look like an expired interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + TIMER_W'(1);
        end
    end

    // The count reads 0 in the cycle after a restart, so matching
    // terminal-1 lets the consumer act on exactly the terminal-th edge.
    assign done = (terminal != '0) && (count == terminal - TIMER_W'(1));

endmodule

// File: rtl/keydecode.sv
// keydecode
// Keypad decoder with press detection, auto-repeat and bad-code blocking.
//   clock     : in  sole clock
//   reset     : in  synchronous active-high reset
//   code      : in  key index, meaningful only while strobe is high
//   strobe    : in  key-held indication, already synchronous to clock
//   onehot    : out 1<<code during an event cycle, otherwise 0
//   keyvalid  : out one-cycle pulse per press or repeat event
//   last_code : out code of the most recent event, held between events
//   held      : out high while a valid key is being held
//   bad_code  : out one-cycle pulse when an out-of-range code blocks input
module keydecode
    import keydecode_pkg::*;
#(
    parameter logic [15:0] REPEAT_DELAY = 16'd50000,
    parameter logic [15:0] REPEAT_RATE  = 16'd10000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CODE_W-1:0]   code,
    input  logic                strobe,
    output logic [NUM_KEYS-1:0] onehot,
    output logic                keyvalid,
    output logic [CODE_W-1:0]   last_code,
    output logic                held,
    output logic                bad_code
);

    localparam logic [NUM_KEYS-1:0] ONE_KEY = NUM_KEYS'(1);

    key_state_t          state;
    key_state_t          state_next;
    logic                ev;
    logic                ev_bad;
    logic [CODE_W-1:0]   ev_code;
    logic                restart;
    logic                timer_done;
    logic [TIMER_W-1:0]  terminal;

    // The first repeat waits the long delay; once repeating, the short rate.
    assign terminal = (state == REPEAT) ? REPEAT_RATE : REPEAT_DELAY;

    repeat_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (restart),
        .terminal (terminal),
        .done     (timer_done)
    );

    // Next-state and event decision. While a key is held, last_code is the
    // key being held, so comparing against it detects a code change. Release
    // and code changes are tested before the timer so they win over a repeat.
    always_comb begin
        state_next = state;
        ev         = 1'b0;
        ev_bad     = 1'b0;
        ev_code    = code;
        restart    = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    if (code_valid(code)) begin
                        ev         = 1'b1;
                        restart    = 1'b1;
                        state_next = DELAY;
                    end else begin
                        ev_bad     = 1'b1;
                        state_next = BLOCKED;
                    end
                end
            end
            BLOCKED: begin
                if (!strobe) begin
                    state_next = IDLE;
                end
            end
            DELAY, REPEAT: begin
                if (!strobe) begin
                    state_next = IDLE;
                end else if (code != last_code) begin
                    if (code_valid(code)) begin
                        ev         = 1'b1;
                        restart    = 1'b1;
                        state_next = DELAY;
                    end else begin
                        ev_bad     = 1'b1;
                        state_next = BLOCKED;
                    end
                end else if (timer_done) begin
                    ev         = 1'b1;
                    ev_code    = last_code;
                    restart    = 1'b1;
                    state_next = REPEAT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            onehot    <= '0;
            keyvalid  <= 1'b0;
            last_code <= '0;
            held      <= 1'b0;
            bad_code  <= 1'b0;
        end else begin
            state     <= state_next;
            keyvalid  <= ev;
            onehot    <= ev ? (ONE_KEY << ev_code) : '0;
            if (ev) begin
                last_code <= ev_code;
            end
            held      <= (state_next == DELAY) || (state_next == REPEAT);
            bad_code  <= ev_bad;
        end
    end

endmodule

// File: tb/tb_keydecode.sv
// tb_keydecode
// Drives two decoders from the same inputs: one with REPEAT_DELAY=4 and
// REPEAT_RATE=2, one with auto-repeat disabled (REPEAT_DELAY=0). Each is
// compared every cycle against a key-level reference model that tracks the
// held key and the absolute cycle number at which its next repeat is due.
module tb_keydecode;

    localparam int NDUT = 2;
    localparam int RATE = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] code = 5'd0;
    logic       strobe = 1'b0;

    logic [19:0] act_oh   [NDUT];
    logic        act_kv   [NDUT];
    logic [4:0]  act_last [NDUT];
    logic        act_held [NDUT];
    logic        act_bad  [NDUT];

    int          mdelay [NDUT] = '{4, 0};
    int          key    [NDUT];
    bit          blk    [NDUT];
    longint      due    [NDUT];
    logic [19:0] e_oh   [NDUT];
    logic        e_kv   [NDUT];
    logic [4:0]  e_last [NDUT];
    logic        e_held [NDUT];
    logic        e_bad  [NDUT];

    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    // Clock generation
    always #5 clock = ~clock;

    keydecode #(.REPEAT_DELAY(16'd4), .REPEAT_RATE(16'd2)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .code      (code),
        .strobe    (strobe),
        .onehot    (act_oh[0]),
        .keyvalid  (act_kv[0]),
        .last_code (act_last[0]),
        .held      (act_held[0]),
        .bad_code  (act_bad[0])
    );

    keydecode #(.REPEAT_DELAY(16'd0), .REPEAT_RATE(16'd2)) dut_z (
        .clock     (clock),
        .reset     (reset),
        .code      (code),
        .strobe    (strobe),
        .onehot    (act_oh[1]),
        .keyvalid  (act_kv[1]),
        .last_code (act_last[1]),
        .held      (act_held[1]),
        .bad_code  (act_bad[1])
    );

    // Record an event for model m carrying key c.
    task automatic emitEvent(input int m, input int c);
        logic [19:0] one;
        one       = 20'd1;
        e_kv[m]   = 1'b1;
        e_oh[m]   = one << c;
        e_last[m] = 5'(c);
    endtask

    // A fresh press: event now, first repeat due REPEAT_DELAY cycles later.
    task automatic pressKey(input int m, input int c);
        emitEvent(m, c);
        key[m] = c;
        due[m] = (mdelay[m] > 0) ? cyc + longint'(mdelay[m]) : -1;
    endtask

    // Advance both reference models by one clock edge using current inputs.
    task automatic modelStep();
        for (int m = 0; m < NDUT; m++) begin
            e_kv[m]  = 1'b0;
            e_bad[m] = 1'b0;
            e_oh[m]  = '0;
            if (reset) begin
                key[m]    = -1;
                blk[m]    = 1'b0;
                e_last[m] = '0;
            end else if (blk[m]) begin
                if (!strobe) blk[m] = 1'b0;
            end else if (key[m] < 0) begin
                if (strobe) begin
                    if (int'(code) < 20) begin
                        pressKey(m, int'(code));
                    end else begin
                        e_bad[m] = 1'b1;
                        blk[m]   = 1'b1;
                    end
                end
            end else if (!strobe) begin
                key[m] = -1;
            end else if (int'(code) != key[m]) begin
                if (int'(code) < 20) begin
                    pressKey(m, int'(code));
                end else begin
                    e_bad[m] = 1'b1;
                    blk[m]   = 1'b1;
                    key[m]   = -1;
                end
            end else if (cyc == due[m]) begin
                emitEvent(m, key[m]);
                due[m] = cyc + longint'(RATE);
            end
            e_held[m] = (key[m] >= 0);
        end
    endtask

    // One comparison of an observed value against the model's value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both decoders with the models.
    task automatic compareAll();
        for (int m = 0; m < NDUT; m++) begin
            checkOutput($sformatf("dut%0d c%0d onehot", m, cyc), 32'(act_oh[m]), 32'(e_oh[m]));
            checkOutput($sformatf("dut%0d c%0d keyvalid", m, cyc), 32'(act_kv[m]), 32'(e_kv[m]));
            checkOutput($sformatf("dut%0d c%0d last_code", m, cyc), 32'(act_last[m]), 32'(e_last[m]));
            checkOutput($sformatf("dut%0d c%0d held", m, cyc), 32'(act_held[m]), 32'(e_held[m]));
            checkOutput($sformatf("dut%0d c%0d bad_code", m, cyc), 32'(act_bad[m]), 32'(e_bad[m]));
        end
    endtask

    // Drive inputs on the falling edge, step the model on the rising edge,
    // then sample the registered outputs just after it.
    task automatic applyStimulus(input logic r, input logic s, input logic [4:0] c);
        @(negedge clock);
        reset  = r;
        strobe = s;
        code   = c;
        @(posedge clock);
        cyc++;
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        logic [11:0] kv_pattern;
        int          kv_count [NDUT];
        logic        s_r;
        logic [4:0]  c_r;
        logic        r_r;

        for (int m = 0; m < NDUT; m++) begin
            key[m] = -1;
            blk[m] = 1'b0;
            due[m] = -1;
        end

        $display("[TB] reset held with strobe=1 code=7");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 5'd7);
        checkOutput("reset onehot", 32'(act_oh[0]), 32'h0);
        checkOutput("reset last_code", 32'(act_last[0]), 32'h0);

        $display("[TB] first edge after reset release is a press of key 7");
        applyStimulus(1'b0, 1'b1, 5'd7);
        checkOutput("press7 onehot", 32'(act_oh[0]), 32'h00080);
        applyStimulus(1'b0, 1'b0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0);

        $display("[TB] hold key 3 for 12 cycles");
        kv_pattern = '0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd3);
            kv_pattern[i] = act_kv[0];
        end
        checkOutput("hold3 keyvalid pattern", 32'(kv_pattern), 32'h551);
        checkOutput("hold3 last_code", 32'(act_last[0]), 32'd3);

        $display("[TB] change to key 19 on a due repeat, keep holding");
        applyStimulus(1'b0, 1'b1, 5'd19);
        checkOutput("key19 onehot", 32'(act_oh[0]), 32'h80000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 5'd19);
        checkOutput("key19 no early repeat", 32'(act_kv[0]), 32'h0);
        applyStimulus(1'b0, 1'b1, 5'd19);
        checkOutput("key19 repeat after 4", 32'(act_kv[0]), 32'h1);

        $display("[TB] bad code 25, then code 2 while still held");
        applyStimulus(1'b0, 1'b1, 5'd25);
        checkOutput("bad25 pulse", 32'(act_bad[0]), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 5'd2);
        applyStimulus(1'b0, 1'b0, 5'd2);
        applyStimulus(1'b0, 1'b1, 5'd2);
        checkOutput("key2 after unblock", 32'(act_oh[0]), 32'h4);
        applyStimulus(1'b0, 1'b0, 5'd0);

        $display("[TB] release on the cycle a repeat is due");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 5'd4);
        applyStimulus(1'b0, 1'b0, 5'd4);
        checkOutput("release-on-due keyvalid", 32'(act_kv[0]), 32'h0);
        checkOutput("release-on-due held", 32'(act_held[0]), 32'h0);

        $display("[TB] hold key 5 for 20 cycles");
        kv_count = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd5);
            for (int m = 0; m < NDUT; m++) kv_count[m] += int'(act_kv[m]);
        end
        checkOutput("nodelay one event", 32'(kv_count[1]), 32'd1);
        checkOutput("delay4 events", 32'(kv_count[0]), 32'd9);

        $display("[TB] reset in the middle of a hold");
        applyStimulus(1'b1, 1'b1, 5'd5);
        applyStimulus(1'b0, 1'b1, 5'd5);
        checkOutput("fresh press after reset", 32'(act_kv[0]), 32'h1);
        applyStimulus(1'b0, 1'b0, 5'd0);

        $display("[TB] randomized traffic");
        s_r = 1'b0;
        c_r = 5'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 12) s_r = ~s_r;
            if ($urandom_range(0, 99) < 10) begin
                if ($urandom_range(0, 99) < 25) c_r = 5'($urandom_range(20, 31));
                else c_r = 5'($urandom_range(0, 19));
            end
            r_r = ($urandom_range(0, 199) == 0);
            applyStimulus(r_r, s_r, c_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
